// File: rtl/bsg_mem_gran_pkg.sv
// Shared constants and helpers for the granule-masked 1R1W synchronous RAM.
package bsg_mem_gran_pkg;

  localparam int LAT_ONE_LP  = 1;
  localparam int LAT_TWO_LP  = 2;
  localparam int MAX_GRAN_LP = 64;

  typedef logic [MAX_GRAN_LP-1:0] gran_word_t;

  function automatic int mask_width_f(input int width, input int gran);
    return (gran > 0) ? (width / gran) : 1;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par_f(input gran_word_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/bsg_mem_gran_bank.sv
// One granule column: storage, S1 read register and same-edge bypass mux.
// Optional parity storage when BSG_MEM_GRAN_PARITY_EN is defined.
module bsg_mem_gran_bank
  import bsg_mem_gran_pkg::*;
#(
  parameter int gran_p       = 8,
  parameter int els_p        = 64,
  parameter int addr_width_p = 6,
  parameter int bypass_p     = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    w_en_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [gran_p-1:0]       w_data_i,
  input  logic                    r_en_i,
  input  logic                    r_addr_ok_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [gran_p-1:0]       s1_data_o
`ifdef BSG_MEM_GRAN_PARITY_EN
  ,
  output logic                    s1_par_o
`endif
);

  logic [gran_p-1:0] mem_q [els_p];
  logic              hit;
  logic [gran_p-1:0] s1_data_d, s1_data_q;

  assign hit = (bypass_p != 0) && w_en_i && (w_addr_i == r_addr_i);

  always_ff @(posedge clk_i) begin
    if (w_en_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign s1_data_d = hit ? w_data_i : (r_addr_ok_i ? mem_q[r_addr_i] : 'x);

  // Only loaded on a read, so the register doubles as the last-read hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  s1_data_q <= '0;
    else if (r_en_i) s1_data_q <= s1_data_d;
  end

  assign s1_data_o = s1_data_q;

`ifdef BSG_MEM_GRAN_PARITY_EN
  logic par_q [els_p];
  logic w_par, s1_par_d, s1_par_q;

  assign w_par = even_par_f(gran_word_t'(w_data_i));

  always_ff @(posedge clk_i) begin
    if (w_en_i) par_q[w_addr_i] <= w_par;
  end

  assign s1_par_d = hit ? w_par : (r_addr_ok_i ? par_q[r_addr_i] : 1'bx);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  s1_par_q <= 1'b0;
    else if (r_en_i) s1_par_q <= s1_par_d;
  end

  assign s1_par_o = s1_par_q;
`endif

endmodule

// File: rtl/bsg_mem_1r1w_sync_mask_write_gran_pipe.sv
// 1R1W sync RAM with granule write masks, 1- or 2-cycle read latency and bypass.
// Per-granule parity is built when BSG_MEM_GRAN_PARITY_EN is defined.
module bsg_mem_1r1w_sync_mask_write_gran_pipe
  import bsg_mem_gran_pkg::*;
#(
  parameter  int width_p           = 32,
  parameter  int els_p             = 64,
  parameter  int gran_p            = 8,
  parameter  int read_latency_p    = 1,
  parameter  int bypass_p          = 1,
  parameter  int latch_last_read_p = 1,
  localparam int mask_width_lp     = mask_width_f(width_p, gran_p),
  localparam int addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_v_o,
  output logic [width_p-1:0]       r_data_o,
  output logic [mask_width_lp-1:0] r_perr_o
);

  if (width_p == 0) begin : g_err_width
    $error("width_p must be nonzero");
  end
  if ((gran_p < 1) || (gran_p > MAX_GRAN_LP)) begin : g_err_gran
    $error("gran_p out of supported range");
  end
  if ((gran_p > 0) && ((width_p % gran_p) != 0)) begin : g_err_mult
    $error("width_p must be a multiple of gran_p");
  end
  if ((read_latency_p != LAT_ONE_LP) && (read_latency_p != LAT_TWO_LP)) begin : g_err_lat
    $error("read_latency_p must be 1 or 2");
  end

  logic                     w_addr_ok, r_addr_ok;
  logic [width_p-1:0]       s1_data;
  logic                     s1_v_q;
  logic                     out_v;
  logic [width_p-1:0]       out_data;
`ifdef BSG_MEM_GRAN_PARITY_EN
  logic [mask_width_lp-1:0] s1_par;
  logic [mask_width_lp-1:0] out_par;
`endif

  if (els_p == (1 << addr_width_lp)) begin : g_pow2
    assign w_addr_ok = 1'b1;
    assign r_addr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);
    assign w_addr_ok = ({1'b0, w_addr_i} < els_lp);
    assign r_addr_ok = ({1'b0, r_addr_i} < els_lp);

    always @(posedge clk_i) begin
      if (reset_n_i && w_v_i) assert (w_addr_ok);
      if (reset_n_i && r_v_i) assert (r_addr_ok);
    end
  end

  for (genvar g = 0; g < mask_width_lp; g++) begin : g_bank
    bsg_mem_gran_bank #(
      .gran_p      (gran_p),
      .els_p       (els_p),
      .addr_width_p(addr_width_lp),
      .bypass_p    (bypass_p)
    ) u_bank (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .w_en_i     (w_v_i & w_mask_i[g] & w_addr_ok),
      .w_addr_i   (w_addr_i),
      .w_data_i   (w_data_i[g*gran_p +: gran_p]),
      .r_en_i     (r_v_i),
      .r_addr_ok_i(r_addr_ok),
      .r_addr_i   (r_addr_i),
      .s1_data_o  (s1_data[g*gran_p +: gran_p])
`ifdef BSG_MEM_GRAN_PARITY_EN
      ,
      .s1_par_o   (s1_par[g])
`endif
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) s1_v_q <= 1'b0;
    else            s1_v_q <= r_v_i;
  end

  if (read_latency_p == LAT_TWO_LP) begin : g_lat2
    logic [addr_width_lp-1:0] s1_addr_q;
    logic                     s2_v_q;
    logic [width_p-1:0]       s2_data_d, s2_data_q;
    logic                     fwd_match;

    // A write landing while the read sits in S1 is forwarded into S2.
    assign fwd_match = (bypass_p != 0) && w_v_i && w_addr_ok && (w_addr_i == s1_addr_q);

    for (genvar g = 0; g < mask_width_lp; g++) begin : g_fwd
      assign s2_data_d[g*gran_p +: gran_p] = (fwd_match && w_mask_i[g])
                                             ? w_data_i[g*gran_p +: gran_p]
                                             : s1_data[g*gran_p +: gran_p];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        s1_addr_q <= '0;
        s2_v_q    <= 1'b0;
        s2_data_q <= '0;
      end else begin
        if (r_v_i)  s1_addr_q <= r_addr_i;
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_data_q <= s2_data_d;
      end
    end

    assign out_v    = s2_v_q;
    assign out_data = s2_data_q;

`ifdef BSG_MEM_GRAN_PARITY_EN
    logic [mask_width_lp-1:0] s2_par_d, s2_par_q;

    for (genvar g = 0; g < mask_width_lp; g++) begin : g_fwd_par
      assign s2_par_d[g] = (fwd_match && w_mask_i[g])
                           ? even_par_f(gran_word_t'(w_data_i[g*gran_p +: gran_p]))
                           : s1_par[g];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)  s2_par_q <= '0;
      else if (s1_v_q) s2_par_q <= s2_par_d;
    end

    assign out_par = s2_par_q;
`endif
  end else begin : g_lat1
    assign out_v    = s1_v_q;
    assign out_data = s1_data;
`ifdef BSG_MEM_GRAN_PARITY_EN
    assign out_par  = s1_par;
`endif
  end

  assign r_v_o = out_v;

  if (latch_last_read_p != 0) begin : g_hold
    assign r_data_o = out_data;
  end else begin : g_zero
    assign r_data_o = out_v ? out_data : '0;
  end

`ifdef BSG_MEM_GRAN_PARITY_EN
  for (genvar g = 0; g < mask_width_lp; g++) begin : g_perr
    assign r_perr_o[g] = out_v &&
      (even_par_f(gran_word_t'(out_data[g*gran_p +: gran_p])) != out_par[g]);
  end
`else
  assign r_perr_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_gran_pipe.sv
// Bench: four configurations share one stimulus stream and are checked each cycle
// against a memory-snapshot model, plus hand-computed literal expectations.
module tb_bsg_mem_1r1w_sync_mask_write_gran_pipe;

  // dut0: lat1 bypass hold; dut1: lat2 bypass hold; dut2: lat2 read-first zero; dut3: lat1 read-first zero
  localparam int LAT_T [4] = '{1, 2, 2, 1};
  localparam int BYP_T [4] = '{1, 1, 0, 0};
  localparam int LCH_T [4] = '{1, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        w_v = 1'b0;
  logic [3:0]  w_mask = '0;
  logic [5:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic        r_v = 1'b0;
  logic [5:0]  r_addr = '0;

  logic        rv [4];
  logic [31:0] rd [4];
  logic [3:0]  rp [4];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    bsg_mem_1r1w_sync_mask_write_gran_pipe #(
      .width_p(32), .els_p(64), .gran_p(8),
      .read_latency_p(LAT_T[k]), .bypass_p(BYP_T[k]), .latch_last_read_p(LCH_T[k])
    ) u_dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .w_v_i(w_v), .w_mask_i(w_mask), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_v_i(r_v), .r_addr_i(r_addr),
      .r_v_o(rv[k]), .r_data_o(rd[k]), .r_perr_o(rp[k])
    );
  end

  // Model state: memory contents, per-granule corruption flags, expected outputs.
  logic [31:0] mem_m [64];
  logic [3:0]  pe_m  [64];
  logic        ev [4];
  logic [31:0] ed [4];
  logic [3:0]  ep [4];
  logic [31:0] last_d [4];
  logic        p_v;
  logic [5:0]  p_addr;
  logic [31:0] p_pre_d;
  logic [3:0]  p_pre_p;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_exp(input int k, input logic v, input logic [31:0] d, input logic [3:0] p);
    ev[k] = v;
    if (v) begin
      ed[k] = d; ep[k] = p; last_d[k] = d;
    end else begin
      ed[k] = (LCH_T[k] != 0) ? last_d[k] : 32'h0;
      ep[k] = 4'h0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, return one cycle later.
  task automatic step(input logic wv, input logic [3:0] wm, input logic [5:0] wa,
                      input logic [31:0] wd, input logic rvi, input logic [5:0] ra);
    logic [31:0] pre_d, post_d;
    logic [3:0]  pre_p, post_p;
    w_v = wv; w_mask = wm; w_addr = wa; w_data = wd; r_v = rvi; r_addr = ra;
    pre_d = mem_m[ra]; pre_p = pe_m[ra];
    if (wv) begin
      for (int g = 0; g < 4; g++) begin
        if (wm[g]) begin
          mem_m[wa][g*8 +: 8] = wd[g*8 +: 8];
          pe_m[wa][g] = 1'b0;
        end
      end
    end
    post_d = mem_m[ra]; post_p = pe_m[ra];
    set_exp(0, rvi, post_d, post_p);
    set_exp(3, rvi, pre_d, pre_p);
    set_exp(1, p_v, mem_m[p_addr], pe_m[p_addr]);
    set_exp(2, p_v, p_pre_d, p_pre_p);
    p_v = rvi; p_addr = ra; p_pre_d = pre_d; p_pre_p = pre_p;
    @(negedge clk); #2;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    w_v = 1'b0; r_v = 1'b0;
    p_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = 1'b0; ed[k] = 32'h0; ep[k] = 4'h0; last_d[k] = 32'h0;
    end
  endtask

  task automatic lit(input string nm, input int k, input logic v_l, input logic [31:0] d_l);
    n_cmp++;
    if (rv[k] !== v_l || rd[k] !== d_l) begin
      n_bad++;
      $display("FAIL %s dut%0d: got v=%b d=%h, want v=%b d=%h", nm, k, rv[k], rd[k], v_l, d_l);
    end
  endtask

  task automatic lit_perr(input string nm, input int k, input logic [3:0] p_l);
    n_cmp++;
    if (rv[k] !== 1'b1 || rp[k] !== p_l) begin
      n_bad++;
      $display("FAIL %s dut%0d: got v=%b perr=%b, want v=1 perr=%b", nm, k, rv[k], rp[k], p_l);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rv[k] !== ev[k] || rd[k] !== ed[k] || rp[k] !== ep[k]) begin
        n_bad++;
        $display("FAIL cycle dut%0d t=%0t: got v=%b d=%h p=%b, want v=%b d=%h p=%b",
                 k, $time, rv[k], rd[k], rp[k], ev[k], ed[k], ep[k]);
      end
    end
  end

  initial begin
    for (int a = 0; a < 64; a++) pe_m[a] = 4'h0;
    apply_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); #2;
    lit("reset_state", 0, 1'b0, 32'h0);
    lit("reset_state", 2, 1'b0, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Full write then latency-1 / latency-2 read
    step(1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
    lit("basic_rd_lat1", 0, 1'b1, 32'hDEADBEEF);
    lit("basic_rd_lat1", 3, 1'b1, 32'hDEADBEEF);
    step(1'b1, 4'hF, 6'd3, 32'h11223344, 1'b0, 6'd0);
    lit("basic_rd_lat2", 1, 1'b1, 32'hDEADBEEF);

    // Granule mask
    step(1'b1, 4'b0101, 6'd3, 32'hAABBCCDD, 1'b0, 6'd0);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd3);
    lit("gran_mask", 0, 1'b1, 32'h11BB33DD);

    // Same-edge collision
    step(1'b1, 4'hF, 6'd7, 32'h0, 1'b0, 6'd0);
    step(1'b1, 4'b0011, 6'd7, 32'hFFFFFFFF, 1'b1, 6'd7);
    lit("same_edge_byp", 0, 1'b1, 32'h0000FFFF);
    lit("same_edge_rdf", 3, 1'b1, 32'h00000000);
    idle();
    lit("same_edge_byp_lat2", 1, 1'b1, 32'h0000FFFF);
    lit("same_edge_rdf_lat2", 2, 1'b1, 32'h00000000);

    // In-flight collision at latency 2
    step(1'b1, 4'hF, 6'd9, 32'hA5A5A5A5, 1'b0, 6'd0);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9);
    lit("inflight_lat1", 0, 1'b1, 32'hA5A5A5A5);
    step(1'b1, 4'b1000, 6'd9, 32'h5A5A5A5A, 1'b0, 6'd0);
    lit("inflight_byp", 1, 1'b1, 32'h5AA5A5A5);
    lit("inflight_rdf", 2, 1'b1, 32'hA5A5A5A5);

    // Back-to-back reads, then idle hold versus zero
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd3);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9);
    idle();
    idle();
    lit("idle_hold", 0, 1'b0, 32'h5AA5A5A5);
    lit("idle_hold", 1, 1'b0, 32'h5AA5A5A5);
    lit("idle_zero", 2, 1'b0, 32'h0);
    lit("idle_zero", 3, 1'b0, 32'h0);

    // Reset while a latency-2 read is in flight
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd9);
    apply_reset();
    @(negedge clk); #2;
    lit("reset_midpipe", 1, 1'b0, 32'h0);
    lit("reset_midpipe", 0, 1'b0, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    idle(); idle(); idle();
    lit("no_stale_pulse", 1, 1'b0, 32'h0);

    // Mixed traffic over a small address window
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'hF, 6'(16 + i), 32'h13579BDF ^ (32'(i) * 32'h01010101), 1'b0, 6'd0);
    for (int i = 0; i < 16; i++) begin
      logic [5:0] wa, ra;
      wa = 6'(16 + (i % 8));
      ra = (i % 4 == 0) ? wa : 6'(16 + ((i + 3) % 8));
      step(1'b1, 4'(i), wa, ~(32'(i) * 32'h00110011), (i % 3 != 2), ra);
    end
    idle(); idle(); idle();

`ifdef BSG_MEM_GRAN_PARITY_EN
    step(1'b1, 4'hF, 6'd12, 32'h12345678, 1'b0, 6'd0);
    g_dut[0].u_dut.g_bank[1].u_bank.mem_q[12][4] = ~g_dut[0].u_dut.g_bank[1].u_bank.mem_q[12][4];
    g_dut[1].u_dut.g_bank[1].u_bank.mem_q[12][4] = ~g_dut[1].u_dut.g_bank[1].u_bank.mem_q[12][4];
    g_dut[2].u_dut.g_bank[1].u_bank.mem_q[12][4] = ~g_dut[2].u_dut.g_bank[1].u_bank.mem_q[12][4];
    g_dut[3].u_dut.g_bank[1].u_bank.mem_q[12][4] = ~g_dut[3].u_dut.g_bank[1].u_bank.mem_q[12][4];
    mem_m[12][12] = ~mem_m[12][12];
    pe_m[12] = 4'b0010;
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd12);
    lit_perr("parity_flip", 0, 4'b0010);
    lit("parity_flip_data", 0, 1'b1, 32'h12344678);
    step(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
    lit_perr("parity_flip_lat2", 1, 4'b0010);
    lit_perr("parity_clean", 0, 4'b0000);
    idle(); idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
